uart_tx_packet_fifo: RTL

- Packet-committing word-to-byte FIFO that feeds the UART TX channel.
- Accepts 32-bit words from the order/report path and releases bytes MSB-first on a first-word-fall-through read-enable interface.
- Only releases whole committed packets. After each packet it forces an empty gap long enough for the TX channel to sample empty and append its footer.
- Packet length is always a multiple of 4 bytes.

---
 rtl/uart_tx_packet_fifo.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_packet_fifo.sv
// Packet-committing 32b->8b FWFT FIFO: first byte visible 2 cycles after the last word of a packet is written.
// Backpressure: s_ready drops while storage is full; oversize packets are dropped; an empty gap follows each packet.
module uart_tx_packet_fifo #(
    parameter int DEPTH_WORDS = 64,
    parameter int GAP_CYCLES  = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_word,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_rd_en,
    output logic        drop_pulse
);
    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [ADDR_W:0]  FULL_COUNT = (ADDR_W + 1)'(DEPTH_WORDS);
    localparam logic [ADDR_W:0]  PTR_ONE    = (ADDR_W + 1)'(1);
    localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_ONE    = GAP_W'(1);

    typedef enum logic {W_ACCEPT, W_DISCARD} w_state_t;
    typedef enum logic [1:0] {R_EMPTY, R_SEND, R_GAP} r_state_t;

    logic [32:0]       r_mem [DEPTH_WORDS];
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_commit_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [31:0]       r_hold;
    logic              r_hold_last;
    logic [1:0]        r_byte_idx;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic              r_drop;
    w_state_t          r_w_state;
    r_state_t          r_r_state;

    logic [ADDR_W:0]   w_used;
    logic              w_full;
    logic              w_oversize;
    logic              w_wr_acc;
    logic              w_commit_avail;
    logic [32:0]       w_mem_rd;

    assign w_used         = r_wr_ptr - r_rd_ptr;
    assign w_full         = (w_used == FULL_COUNT);
    // Storage full of one uncommitted packet: it can never drain, so it must be thrown away.
    assign w_oversize     = (r_w_state == W_ACCEPT) && w_full && (r_commit_ptr == r_rd_ptr) && s_valid;
    assign w_wr_acc       = (r_w_state == W_ACCEPT) && s_valid && !w_full;
    assign w_commit_avail = (r_rd_ptr != r_commit_ptr);
    assign w_mem_rd       = r_mem[r_rd_ptr[ADDR_W-1:0]];

    assign s_ready    = (r_w_state == W_DISCARD) || !w_full || w_oversize;
    assign m_valid    = (r_r_state == R_SEND);
    assign drop_pulse = r_drop;

    always_comb begin
        m_data = 8'h00;
        case (r_byte_idx)
            2'd0:    m_data = r_hold[31:24];
            2'd1:    m_data = r_hold[23:16];
            2'd2:    m_data = r_hold[15:8];
            default: m_data = r_hold[7:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= {s_last, s_word};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_drop       <= 1'b0;
            r_w_state    <= W_ACCEPT;
        end else begin
            r_drop <= 1'b0;
            case (r_w_state)
                W_ACCEPT: begin
                    if (w_oversize) begin
                        r_wr_ptr <= r_commit_ptr;
                        r_drop   <= 1'b1;
                        if (!s_last) begin
                            r_w_state <= W_DISCARD;
                        end
                    end else if (w_wr_acc) begin
                        r_wr_ptr <= r_wr_ptr + PTR_ONE;
                        if (s_last) begin
                            r_commit_ptr <= r_wr_ptr + PTR_ONE;
                        end
                    end
                end
                W_DISCARD: begin
                    if (s_valid && s_last) begin
                        r_w_state <= W_ACCEPT;
                    end
                end
                default: r_w_state <= W_ACCEPT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr    <= '0;
            r_hold      <= '0;
            r_hold_last <= 1'b0;
            r_byte_idx  <= 2'd0;
            r_gap_cnt   <= '0;
            r_r_state   <= R_EMPTY;
        end else begin
            case (r_r_state)
                R_EMPTY: begin
                    if (w_commit_avail) begin
                        r_hold      <= w_mem_rd[31:0];
                        r_hold_last <= w_mem_rd[32];
                        r_rd_ptr    <= r_rd_ptr + PTR_ONE;
                        r_byte_idx  <= 2'd0;
                        r_r_state   <= R_SEND;
                    end
                end
                R_SEND: begin
                    if (m_rd_en) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            if (r_hold_last) begin
                                r_gap_cnt <= GAP_LOAD;
                                r_r_state <= (GAP_CYCLES == 0) ? R_EMPTY : R_GAP;
                            end else if (w_commit_avail) begin
                                // Chain straight into the next word so the packet has no bubble.
                                r_hold      <= w_mem_rd[31:0];
                                r_hold_last <= w_mem_rd[32];
                                r_rd_ptr    <= r_rd_ptr + PTR_ONE;
                            end else begin
                                r_r_state <= R_EMPTY;
                            end
                        end
                    end
                end
                R_GAP: begin
                    r_gap_cnt <= r_gap_cnt - GAP_ONE;
                    if (r_gap_cnt <= GAP_ONE) begin
                        r_r_state <= R_EMPTY;
                    end
                end
                default: r_r_state <= R_EMPTY;
            endcase
        end
    end
endmodule
